ads127x_frame_reader: RTL

Parametrised successor to the single-purpose ADS1278 driver. Generates frame-sync and SCLK for an ADS127x-family ADC (frame-sync format), shifts in P_CH_NUM parallel DOUT lanes of P_DATA_W bits, and presents each frame on a valid/ready output register. Runs on one system clock with an internal SCLK divider. Sits between the ADC pins and the acquisition FIFO/packetiser.

---
 rtl/ads127x_frame_reader_pkg.sv | 16 +
 rtl/ads127x_frame_reader_if.sv | 14 +
 rtl/ads127x_frame_reader_sclk_gen.sv | 44 ++++
 rtl/ads127x_frame_reader.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/ads127x_frame_reader_pkg.sv
// Shared FSM state type and fixed ADC strap levels for the ADS127x frame reader.
package adc_rdr_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FSYNC,
    SHIFT,
    STORE
  } state_e;

  localparam logic [2:0] ADC_FORMAT  = 3'b101;
  localparam logic [1:0] ADC_TEST    = 2'b00;
  localparam logic       ADC_SYNC    = 1'b1;
  localparam int         FRAME_CNT_W = 16;

endpackage

// File: rtl/ads127x_frame_reader_if.sv
// Valid/ready frame output bus between the ADC frame reader and its consumer.
interface ads127x_frame_reader_if #(
  parameter int P_CH_NUM = 8,
  parameter int P_DATA_W = 24
);

  logic [P_CH_NUM*P_DATA_W-1:0] o_rdata;
  logic                         o_rdata_valid;
  logic                         i_rdata_ready;

  modport master (output o_rdata, output o_rdata_valid, input i_rdata_ready);
  modport slave  (input o_rdata, input o_rdata_valid, output i_rdata_ready);

endinterface

// File: rtl/ads127x_frame_reader_sclk_gen.sv
// SCLK divider: low for P_SCLK_DIV sysclks then high for P_SCLK_DIV, idles high when disabled.
module adc_sclk_gen #(
  parameter int P_SCLK_DIV = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  output logic sclk_o,
  output logic sample_o,
  output logic bit_done_o
);

  localparam int PosW = $clog2(2 * P_SCLK_DIV);
  localparam logic [PosW-1:0] PosHigh = PosW'(P_SCLK_DIV);
  localparam logic [PosW-1:0] PosLast = PosW'(2 * P_SCLK_DIV - 1);

  logic [PosW-1:0] pos_q, pos_d;
  logic            sclk_q, sclk_d;

  // sclk is registered from the current position, so it lags pos by one cycle
  always_comb begin
    pos_d  = '0;
    sclk_d = 1'b1;
    if (en_i) begin
      pos_d  = (pos_q == PosLast) ? '0 : pos_q + 1'b1;
      sclk_d = (pos_q >= PosHigh);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pos_q  <= '0;
      sclk_q <= 1'b1;
    end else begin
      pos_q  <= pos_d;
      sclk_q <= sclk_d;
    end
  end

  assign sclk_o     = sclk_q;
  assign sample_o   = en_i && (pos_q == PosHigh);
  assign bit_done_o = en_i && (pos_q == PosLast);

endmodule

// File: rtl/ads127x_frame_reader.sv
// ADS127x frame-sync reader: drives FSYNC/SCLK, shifts P_CH_NUM DOUT lanes, presents frames on valid/ready.
// Optional build macro ADC_RDR_TESTPAT_EN adds a counting test pattern selected by i_testpat.
module ads127x_frame_reader
  import adc_rdr_pkg::*;
#(
  parameter int         P_CH_NUM     = 8,
  parameter int         P_DATA_W     = 24,
  parameter int         P_SCLK_DIV   = 2,
  parameter int         P_FRAME_CLKS = 512,
  parameter logic [1:0] P_ADC_MODE   = 2'b01,
  parameter logic [7:0] P_ADC_PWDN   = 8'hFF
) (
  input  logic                   i_sysclk,
  input  logic                   i_rst_n,
  input  logic                   i_start,
  input  logic                   i_ovf_clr,
  input  logic                   i_testpat,
  output logic                   o_adc_fsync,
  output logic                   o_adc_sclk,
  input  logic [P_CH_NUM-1:0]    i_adc_dout,
  output logic [1:0]             o_adc_mode,
  output logic [7:0]             o_adc_pwdn,
  output logic [2:0]             o_adc_format,
  output logic                   o_adc_sync,
  output logic [1:0]             o_adc_test,
  ads127x_frame_reader_if.master rd_if,
  output logic                   o_overflow,
  output logic [FRAME_CNT_W-1:0] o_frame_cnt
);

  localparam int PerW  = $clog2(P_FRAME_CLKS);
  localparam int StepW = $clog2(2 * P_SCLK_DIV + P_DATA_W + 1);

  if (P_FRAME_CLKS < 2 * P_SCLK_DIV * (P_DATA_W + 1) + 4) begin : g_frame_chk
    $error("ads127x_frame_reader: P_FRAME_CLKS too short for one frame");
  end

  state_e                             state_q, state_d;
  logic [StepW-1:0]                   step_q, step_d;
  logic [PerW-1:0]                    period_q, period_d;
  logic                               fsync_q;
  logic [P_CH_NUM-1:0][P_DATA_W-1:0]  shreg_q, shreg_d, frame_data;
  logic [P_CH_NUM*P_DATA_W-1:0]       rdata_q, rdata_d;
  logic                               valid_q, valid_d;
  logic                               ovf_q, ovf_d;
  logic [FRAME_CNT_W-1:0]             fcnt_q, fcnt_d;
  logic                               tick, sclk_en, sample, bit_done;
  logic                               store, load, drop, accept;

  assign tick     = (period_q == PerW'(P_FRAME_CLKS - 1));
  assign period_d = (!i_start || tick) ? '0 : period_q + 1'b1;
  assign sclk_en  = (state_q == SHIFT) && i_start;

  adc_sclk_gen #(.P_SCLK_DIV(P_SCLK_DIV)) u_sclk_gen (
    .clk_i      (i_sysclk),
    .rst_ni     (i_rst_n),
    .en_i       (sclk_en),
    .sclk_o     (o_adc_sclk),
    .sample_o   (sample),
    .bit_done_o (bit_done)
  );

  // step_q counts sysclks in FSYNC and completed bits in SHIFT
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    case (state_q)
      IDLE: if (tick) begin
        state_d = FSYNC;
        step_d  = '0;
      end
      FSYNC: if (step_q == StepW'(2 * P_SCLK_DIV - 1)) begin
        state_d = SHIFT;
        step_d  = '0;
      end else begin
        step_d = step_q + 1'b1;
      end
      SHIFT: if (bit_done) begin
        if (step_q == StepW'(P_DATA_W - 1)) begin
          state_d = STORE;
          step_d  = '0;
        end else begin
          step_d = step_q + 1'b1;
        end
      end
      STORE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (!i_start) begin
      state_d = IDLE;
      step_d  = '0;
    end
  end

  always_comb begin
    shreg_d = shreg_q;
    if (sample) begin
      for (int k = 0; k < P_CH_NUM; k++) begin
        shreg_d[k] = {shreg_q[k][P_DATA_W-2:0], i_adc_dout[k]};
      end
    end
  end

`ifdef ADC_RDR_TESTPAT_EN
  always_comb begin
    frame_data = shreg_q;
    if (i_testpat) begin
      for (int k = 0; k < P_CH_NUM; k++) begin
        frame_data[k] = P_DATA_W'(fcnt_q) + P_DATA_W'(k);
      end
    end
  end
`else
  logic unused_testpat;
  assign unused_testpat = i_testpat;
  assign frame_data     = shreg_q;
`endif

  // A completed frame replaces the output only if the slot is free or being drained this cycle
  always_comb begin
    accept  = valid_q && rd_if.i_rdata_ready;
    store   = (state_q == STORE) && i_start;
    load    = store && (!valid_q || rd_if.i_rdata_ready);
    drop    = store && valid_q && !rd_if.i_rdata_ready;
    rdata_d = load ? frame_data : rdata_q;
    valid_d = load ? 1'b1 : (accept ? 1'b0 : valid_q);
    ovf_d   = drop ? 1'b1 : (i_ovf_clr ? 1'b0 : ovf_q);
    fcnt_d  = load ? fcnt_q + 1'b1 : fcnt_q;
  end

  always_ff @(posedge i_sysclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      step_q   <= '0;
      period_q <= '0;
      fsync_q  <= 1'b0;
      shreg_q  <= '0;
      rdata_q  <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
      fcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      period_q <= period_d;
      fsync_q  <= (state_d == FSYNC);
      shreg_q  <= shreg_d;
      rdata_q  <= rdata_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
      fcnt_q   <= fcnt_d;
    end
  end

  assign o_adc_fsync         = fsync_q;
  assign rd_if.o_rdata       = rdata_q;
  assign rd_if.o_rdata_valid = valid_q;
  assign o_overflow          = ovf_q;
  assign o_frame_cnt         = fcnt_q;
  assign o_adc_mode          = P_ADC_MODE;
  assign o_adc_pwdn          = P_ADC_PWDN;
  assign o_adc_format        = ADC_FORMAT;
  assign o_adc_sync          = ADC_SYNC;
  assign o_adc_test          = ADC_TEST;

endmodule
